dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and access sequencer for the shared 256x32 data memory.
//  Port 0 is the CPU load/store unit; port 1 is the debug/DMA loader.
//  One transaction is outstanding at a time; each port has a valid/ready request and response handshake.
//  Drives the memory A/WD/WE/RD interface.
//  The memory commits WD at A on every clock edge and ignores WE, so this block must keep idle cycles benign.
// PARAMETERS
//  DEPTH    256  words in the data memory; legal word addresses are 0..DEPTH-1
//  DATA_W   32   data width
//  CNT_W    16   width of the per-port saturating transaction counters
// PORTS
//  clk          in   1       clock
//  reset        in   1       asynchronous, active-low reset
//  req_valid    in   [1:0]   request valid, per port
//  req_ready    out  [1:0]   request accepted when valid&ready; at most one bit high
//  req_we       in   [1:0]   1 = write, 0 = read
//  req_addr     in   2x32    word address, per port
//  req_wdata    in   2x32    write data, per port
//  rsp_valid    out  [1:0]   response valid; held until rsp_ready
//  rsp_ready    in   [1:0]   response consumed
//  rsp_rdata    out  32      read data (shared; qualified by rsp_valid)
//  rsp_err      out  1       address out of range (qualified by rsp_valid)
//  mem_a        out  32      memory address
//  mem_wd       out  32      memory write data
//  mem_we       out  1       memory write enable
//  mem_rd       in   32      memory combinational read data
//  txn_cnt      out  2xCNT_W completed transactions per port, saturating at all-ones
// BEHAVIOUR
//  Reset (async, reset=0) values:
//   - FSM = IDLE; rr pointer = port 0; req_ready = 0; rsp_valid = 0
//   - rsp_rdata = 0; rsp_err = 0; txn_cnt = 0; captured registers = 0
//  Reset mid-operation:
//   - An in-flight transaction is abandoned and no response is issued.
//   - The memory is reinitialised by its own reset.
//  FSM states:
//   - IDLE: req_ready = grant vector.
//     - Grant goes to the sole requester, or to the rr-pointer port if both request.
//     - On valid&ready: capture port/we/addr/wdata, move the pointer to the other port, go to ACCESS.
//   - ACCESS (1 cycle): mem_a = captured addr.
//     - In range, write: mem_we = 1, mem_wd = wdata.
//     - In range, read: mem_we = 0, mem_wd = mem_rd (write-back of the current word).
//     - Out of range (addr >= DEPTH): mem_a = 0, mem_we = 0, mem_wd = mem_rd.
//     - Register rsp_rdata = mem_rd for an in-range read, else 0; rsp_err = out-of-range; go to RESP.
//   - RESP: rsp_valid[port] = 1; rdata and err are held stable.
//     - On rsp_ready[port]: increment txn_cnt[port] (saturating), go to IDLE.
//  Idle-cycle memory drive: in IDLE and RESP, mem_a = 0, mem_we = 0, mem_wd = mem_rd.
//   - So the memory never sees a spurious write.
//  Latency: accept at edge N -> memory write commits at edge N+1 -> rsp_valid high after edge N+1.
//   - Minimum 3 cycles per transaction; req_ready is never high outside IDLE.
//  Ordering: a read issued after a completed write to the same address returns the new data.
//  Fairness: while both ports request continuously, grants strictly alternate.
//  Address compare uses the full 32 bits; no wrap-around of high addresses into range.
// STRUCTURE
//  Package dmem_arb_pkg:
//   - state_t enum {IDLE, ACCESS, RESP}
//   - port_t (1-bit port index)
//   - DEPTH_DEF = 256 and DATA_W_DEF = 32 constants
//  Sub-module rr_arbiter2: inputs req[1:0], advance; output gnt[1:0] (one-hot or zero); internal pointer flop.
//  The top level holds the FSM, capture registers, memory drive mux and counters.
// TESTING (bench instantiates the real data memory)
//  1. After reset: port 1 reads addr 5 -> rsp_rdata = 5, rsp_err = 0; rsp_valid[1] rises 2 cycles after accept.
//  2. Port 0 writes 0xDEADBEEF to addr 1, then reads addr 1 -> returns 0xDEADBEEF; addresses 0 and 2 are unchanged (0, 2).
//  3. Both ports valid for 6 requests each -> grants alternate 0,1,0,1...; txn_cnt = 6 each.
//  4. Port 0 writes to addr 300 -> rsp_err = 1, rsp_rdata = 0; memory words 0..255 are unchanged.
//  5. Hold rsp_ready[0] = 0 for 5 cycles -> rsp_valid and rdata stay stable; no req_ready to port 1 until release.
//  6. Assert reset in ACCESS of a write -> rsp_valid = 0, FSM in IDLE; memory is back to reset contents after release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
//   state_t    : sequencer states (IDLE -> ACCESS -> RESP)
//   port_t     : 1-bit requester index (0 = CPU LSU, 1 = debug/DMA loader)
//   *_DEF      : default geometry of the shared data memory and counters
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  typedef logic port_t;

  localparam int unsigned DEPTH_DEF  = 256;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  function automatic logic [1:0] port_onehot(port_t p);
    return p ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter.
//   clk, reset : clock, asynchronous active-low reset
//   req        : request vector
//   advance    : a grant was taken this cycle; hand priority to the other port
//   gnt        : one-hot grant, or zero when nobody requests
module rr_arbiter2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  port_t ptr_q;

  // The pointer only matters when both ports request at once.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = port_onehot(ptr_q);
      default: gnt = 2'b00;
    endcase
  end

  // Priority moves to the port that was not just granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      ptr_q <= ~gnt[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for the shared data memory.
// One transaction is in flight at a time: IDLE (grant) -> ACCESS (one memory cycle) -> RESP
// (hold response until consumed). The memory writes mem_wd at mem_a on every edge, so every
// cycle that is not a genuine in-range write re-writes the addressed word with its own value.
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/ready/we    : per-port request handshake and direction
//   req_addr, req_wdata   : per-port word address and write data
//   rsp_valid/ready       : per-port response handshake
//   rsp_rdata, rsp_err    : shared response data and out-of-range flag
//   mem_a/wd/we, mem_rd   : data memory interface
//   txn_cnt               : per-port saturating completed-transaction counters
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0][31:0]       req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [31:0]            mem_a,
  output logic [DATA_W-1:0]      mem_wd,
  output logic                   mem_we,
  input  logic [DATA_W-1:0]      mem_rd,
  output logic [1:0][CNT_W-1:0]  txn_cnt
);

  state_t                  state_q;
  port_t                   port_q;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [1:0]              rsp_valid_q;
  logic [DATA_W-1:0]       rdata_q;
  logic                    err_q;
  logic [1:0][CNT_W-1:0]   cnt_q;

  logic [1:0] gnt;
  logic       accept;
  port_t      gnt_port;
  logic       in_range;

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign accept    = |(req_valid & req_ready);
  assign gnt_port  = port_t'(gnt[1]);
  // Full 32-bit compare: high addresses must not alias into the array.
  assign in_range  = (addr_q < 32'(DEPTH));

  // Default drive is a benign write-back of word 0 onto itself.
  always_comb begin
    mem_a  = '0;
    mem_we = 1'b0;
    mem_wd = mem_rd;
    if (state_q == ACCESS && in_range) begin
      mem_a = addr_q;
      if (we_q) begin
        mem_we = 1'b1;
        mem_wd = wdata_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            port_q  <= gnt_port;
            we_q    <= req_we[gnt_port];
            addr_q  <= req_addr[gnt_port];
            wdata_q <= req_wdata[gnt_port];
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          rdata_q     <= (in_range && !we_q) ? mem_rd : '0;
          err_q       <= !in_range;
          rsp_valid_q <= port_onehot(port_q);
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready[port_q]) begin
            rsp_valid_q <= '0;
            if (cnt_q[port_q] != '1) begin
              cnt_q[port_q] <= cnt_q[port_q] + CNT_W'(1);
            end
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_cnt   = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter with a behavioural 256x32 data memory (reset contents word[i] = i,
// commits mem_wd at mem_a on every edge). Expected results come from a reference array,
// per-port counters and a round-robin priority variable updated from the transaction rules.
module tb_dmem_arbiter;

  logic              clk;
  logic              reset;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_we;
  logic [1:0][31:0]  req_addr;
  logic [1:0][31:0]  req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic [31:0]       mem_a;
  logic [31:0]       mem_wd;
  logic              mem_we;
  logic [31:0]       mem_rd;
  logic [1:0][15:0]  txn_cnt;

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .txn_cnt   (txn_cnt)
  );

  // Data memory: ignores mem_we and commits every edge.
  logic [31:0] mem [256];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
    end else if (mem_a < 32'd256) begin
      mem[mem_a[7:0]] <= mem_wd;
    end
  end
  assign mem_rd = (mem_a < 32'd256) ? mem[mem_a[7:0]] : 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          cnt_m [2];
  int          rr_m;
  int          tests;
  int          fails;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i);
    cnt_m[0] = 0;
    cnt_m[1] = 0;
    rr_m     = 0;
  endtask

  task automatic set_req(input int p, input bit we, input logic [31:0] a, input logic [31:0] d);
    req_we[p]    = we;
    req_addr[p]  = a;
    req_wdata[p] = d;
    req_valid[p] = 1'b1;
  endtask

  // Runs one transaction from IDLE to completion; the DUT is expected to be idle on entry.
  task automatic serve(input int hold, input bit raise_other, output int gp);
    int          p;
    int          n;
    bit          w;
    bit          oor;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    #1;
    if (req_valid == 2'b11) p = rr_m;
    else p = req_valid[1] ? 1 : 0;
    gp = p;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant", 32'(req_ready), (p == 1) ? 32'd2 : 32'd1);
    check("grant_latency", n, 0);
    w   = req_we[p];
    a   = req_addr[p];
    wd  = req_wdata[p];
    oor = (a >= 32'd256);
    exp_rd = (!oor && !w) ? ref_mem[a[7:0]] : 32'd0;
    if (!oor && w) ref_mem[a[7:0]] = wd;
    rr_m = 1 - p;
    @(negedge clk);
    req_valid[p] = 1'b0;
    if (raise_other) req_valid[1-p] = 1'b1;
    #1;
    check("access_req_ready", 32'(req_ready), 0);
    check("access_rsp_valid", 32'(rsp_valid), 0);
    check("access_mem_a", mem_a, oor ? 32'd0 : a);
    check("access_mem_we", 32'(mem_we), 32'(!oor && w));
    @(negedge clk);
    for (int i = 0; i <= hold; i++) begin
      check("rsp_valid", 32'(rsp_valid), (p == 1) ? 32'd2 : 32'd1);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_err", 32'(rsp_err), 32'(oor));
      check("rsp_req_ready", 32'(req_ready), 0);
      check("rsp_mem_we", 32'(mem_we), 0);
      if (i < hold) @(negedge clk);
    end
    rsp_ready[p] = 1'b1;
    @(negedge clk);
    rsp_ready[p] = 1'b0;
    if (cnt_m[p] < 65535) cnt_m[p]++;
    check("txn_cnt0", 32'(txn_cnt[0]), 32'(cnt_m[0]));
    check("txn_cnt1", 32'(txn_cnt[1]), 32'(cnt_m[1]));
    check("rsp_valid_clear", 32'(rsp_valid), 0);
  endtask

  task automatic check_mem_all(input string tag);
    int diffs;
    diffs = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  initial begin
    int gp;
    int prev_gp;
    int left [2];
    tests     = 0;
    fails     = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = '0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", 32'(rsp_err), 0);
    check("rst_cnt", 32'(txn_cnt), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_a", mem_a, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Port 1 reads word 5 straight after reset.
    set_req(1, 1'b0, 32'd5, 32'd0);
    serve(0, 1'b0, gp);

    // Write then read back on port 0; neighbours untouched.
    set_req(0, 1'b1, 32'd1, 32'hDEADBEEF);
    serve(0, 1'b0, gp);
    set_req(0, 1'b0, 32'd1, 32'd0);
    serve(0, 1'b0, gp);
    check("mem_word0", mem[0], 32'd0);
    check("mem_word1", mem[1], 32'hDEADBEEF);
    check("mem_word2", mem[2], 32'd2);

    // Fairness from a clean reset: both ports request six times each.
    pulse_reset();
    left[0] = 6;
    left[1] = 6;
    prev_gp = 1;
    set_req(0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 299)), $urandom);
    set_req(1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 299)), $urandom);
    for (int i = 0; i < 12; i++) begin
      serve(0, 1'b0, gp);
      check("fair_alternate", gp, 1 - prev_gp);
      prev_gp = gp;
      left[gp]--;
      if (left[gp] > 0)
        set_req(gp, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 299)), $urandom);
    end
    check("fair_cnt0", 32'(txn_cnt[0]), 32'd6);
    check("fair_cnt1", 32'(txn_cnt[1]), 32'd6);
    check_mem_all("mem_after_fair");

    // Out-of-range and boundary addresses.
    set_req(0, 1'b1, 32'd300, 32'hA5A5A5A5);
    serve(0, 1'b0, gp);
    set_req(1, 1'b1, 32'h0000_0100, 32'h11111111);
    serve(0, 1'b0, gp);
    set_req(0, 1'b0, 32'h8000_0005, 32'd0);
    serve(0, 1'b0, gp);
    set_req(1, 1'b1, 32'd255, 32'hCAFEF00D);
    serve(0, 1'b0, gp);
    set_req(0, 1'b0, 32'd255, 32'd0);
    serve(0, 1'b0, gp);
    check_mem_all("mem_after_oor");

    // Port 0 response stalled for five cycles while port 1 waits.
    req_we[1]    = 1'b0;
    req_addr[1]  = 32'd255;
    req_wdata[1] = 32'd0;
    set_req(0, 1'b0, 32'($urandom_range(0, 255)), 32'd0);
    serve(5, 1'b1, gp);
    serve(0, 1'b0, gp);
    check("stall_port1_served", gp, 1);

    // Random traffic.
    for (int i = 0; i < 40; i++) begin
      for (int q = 0; q < 2; q++)
        if (!req_valid[q] && $urandom_range(0, 1) == 1)
          set_req(q, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 299)), $urandom);
      if (req_valid == 2'b00)
        set_req(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                32'($urandom_range(0, 299)), $urandom);
      serve(int'($urandom_range(0, 2)), 1'b0, gp);
    end
    while (req_valid != 2'b00) serve(0, 1'b0, gp);
    check_mem_all("mem_after_random");

    // Reset during the ACCESS cycle of a write.
    set_req(0, 1'b1, 32'd7, 32'h12345678);
    #1;
    check("abort_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = '0;
    #1;
    check("abort_in_access_we", 32'(mem_we), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_rsp_valid", 32'(rsp_valid), 0);
    check("abort_cnt", 32'(txn_cnt), 0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    check("abort_no_rsp", 32'(rsp_valid), 0);
    check("abort_mem7", mem[7], 32'd7);
    check_mem_all("mem_after_abort");
    set_req(0, 1'b0, 32'd7, 32'd0);
    serve(0, 1'b0, gp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
